// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the ID-stage controller (master) and the ALU op sequencer (slave).
interface alu_op_sequencer_if #(
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        aluop;
    logic [5:0]        funct;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alucontrol;
    logic              multi;
    logic              busy;
    logic              stall;

    modport master (
        output in_valid, aluop, funct, flush, out_ready,
        input  in_ready, out_valid, alucontrol, multi, busy, stall
    );

    modport slave (
        input  in_valid, aluop, funct, flush, out_ready,
        output in_ready, out_valid, alucontrol, multi, busy, stall
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered ALU control decoder with valid/ready flow control and a multiplier occupancy window.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
module alu_op_sequencer #(
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);

    function automatic logic [4:0] decode(input logic [3:0] aluop, input logic [5:0] funct);
        logic [4:0] code;
        code = 5'd0;
        case (aluop)
            4'd0: begin
                case (funct)
                    6'b100000: code = 5'd0;
                    6'b100001: code = 5'd1;
                    6'b100010: code = 5'd2;
                    6'b011000: code = 5'd3;
                    6'b011001: code = 5'd4;
                    6'b100100: code = 5'd5;
                    6'b100101: code = 5'd6;
                    6'b100111: code = 5'd7;
                    6'b100110: code = 5'd8;
                    6'b000000: code = 5'd9;
                    6'b000010: code = 5'd10;
                    6'b000100: code = 5'd11;
                    6'b101010: code = 5'd12;
                    6'b001011: code = 5'd13;
                    6'b001010: code = 5'd14;
                    6'b000110: code = 5'd15;
                    6'b000011: code = 5'd16;
                    6'b000111: code = 5'd17;
                    6'b101011: code = 5'd18;
                    default:   code = 5'd0;
                endcase
            end
            4'd1:  code = 5'd0;
            4'd2:  code = 5'd2;
            4'd3:  code = 5'd6;
            4'd4:  code = 5'd5;
            4'd5:  code = 5'd8;
            4'd6:  code = 5'd7;
            4'd7:  code = 5'd1;
            4'd8:  code = 5'd2;
            4'd9:  code = 5'd3;
            4'd10: code = 5'd12;
            4'd11: code = 5'd12;
            4'd12: begin
                case (funct)
                    6'b000010: code = 5'd19;
                    6'b000000: code = 5'd20;
                    6'b000100: code = 5'd21;
                    default:   code = 5'd0;
                endcase
            end
            default: code = 5'd0;
        endcase
        return code;
    endfunction

    // Only these codes occupy the multiplier; undefined encodings decode to 0 and never qualify.
    function automatic logic is_multi(input logic [4:0] code);
        return (code == 5'd3) || (code == 5'd4) || (code == 5'd19) ||
               (code == 5'd20) || (code == 5'd21);
    endfunction

    logic [4:0]        code_p0;
    logic              multi_p0;
    logic              vld_p1;
    logic              multi_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [3:0]        busy_cnt;
    logic              busy;
    logic              in_ready;
    logic              accept;
    logic              xfer;
    logic              stall;

    always_comb begin
        code_p0  = decode(bus.aluop, bus.funct);
        multi_p0 = is_multi(code_p0);
        busy     = (busy_cnt != 4'd0);
        in_ready = !busy && (!vld_p1 || bus.out_ready) && !bus.flush;
        accept   = bus.in_valid && in_ready;
        xfer     = vld_p1 && bus.out_ready;
        stall    = bus.in_valid && !in_ready;
    end

    // Stage p0 -> p1: decoded op captured into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            multi_p1 <= 1'b0;
            ctrl_p1  <= '0;
            busy_cnt <= 4'd0;
        end else if (bus.flush) begin
            vld_p1   <= 1'b0;
            multi_p1 <= 1'b0;
            busy_cnt <= 4'd0;
        end else begin
            if (accept) begin
                vld_p1   <= 1'b1;
                ctrl_p1  <= CTRL_W'(code_p0);
                multi_p1 <= multi_p0;
            end else if (xfer) begin
                vld_p1 <= 1'b0;
            end
            // With MUL_CYCLES=0 the load value is zero, so the window never opens.
            if (xfer && multi_p1) begin
                busy_cnt <= MUL_LOAD;
            end else if (busy) begin
                busy_cnt <= busy_cnt - 4'd1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_p1;
    assign bus.alucontrol = ctrl_p1;
    assign bus.multi      = multi_p1;
    assign bus.busy       = busy;
    assign bus.stall      = stall;

`ifdef ALU_SEQ_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (xfer) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: two instances (MUL_CYCLES=4 and 0) against a reference model.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.CTRL_W(5)) bus4 ();
    alu_op_sequencer_if #(.CTRL_W(5)) bus0 ();

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] pi4, ps4, pi0, ps0;
`endif

    alu_op_sequencer #(.CTRL_W(5), .MUL_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
`ifdef ALU_SEQ_PERF_EN
        , .perf_issued(pi4), .perf_stall(ps4)
`endif
    );

    alu_op_sequencer #(.CTRL_W(5), .MUL_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
`ifdef ALU_SEQ_PERF_EN
        , .perf_issued(pi0), .perf_stall(ps0)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference tables: position in funct_tab is the code for AluOp=0; imm_tab is indexed by AluOp.
    int funct_tab [19] = '{'h20, 'h21, 'h22, 'h18, 'h19, 'h24, 'h25, 'h27, 'h26, 'h00,
                           'h02, 'h04, 'h2a, 'h0b, 'h0a, 'h06, 'h03, 'h07, 'h2b};
    int imm_tab [12] = '{0, 0, 2, 6, 5, 8, 7, 1, 2, 3, 12, 12};
    int mc [2] = '{4, 0};

    bit m_vld [2];
    int m_ctrl [2];
    bit m_multi [2];
    int m_rem [2];
    int m_iss [2];
    int m_stl [2];
    bit acc_last [2];

    bit s_iv, s_fl, s_ordy;
    int s_aop, s_fn;

    function automatic int ref_code(input int aop, input int fn);
        if (aop == 0) begin
            for (int i = 0; i < 19; i++) if (funct_tab[i] == fn) return i;
            return 0;
        end
        if (aop <= 11) return imm_tab[aop];
        if (aop == 12) return (fn == 2) ? 19 : (fn == 0) ? 20 : (fn == 4) ? 21 : 0;
        return 0;
    endfunction

    function automatic bit ref_multi(input int code);
        return (code == 3) || (code == 4) || (code >= 19 && code <= 21);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 0; m_ctrl[d] = 0; m_multi[d] = 0; m_rem[d] = 0;
            m_iss[d] = 0; m_stl[d] = 0; acc_last[d] = 0;
        end
    endtask

    task automatic set_in(input bit iv, input int aop, input int fn, input bit fl, input bit ordy);
        s_iv = iv; s_aop = aop; s_fn = fn; s_fl = fl; s_ordy = ordy;
        bus4.in_valid = iv; bus4.aluop = 4'(aop); bus4.funct = 6'(fn);
        bus4.flush = fl; bus4.out_ready = ordy;
        bus0.in_valid = iv; bus0.aluop = 4'(aop); bus0.funct = 6'(fn);
        bus0.flush = fl; bus0.out_ready = ordy;
    endtask

    task automatic step(input int d, input logic ov, input logic [4:0] ac, input logic mu,
                        input logic bs, input logic ir, input logic st);
        bit busy, irdy, xfer, acc;
        int nrem;
        string p;
        p = (d == 0) ? "m4" : "m0";
        busy = (m_rem[d] != 0);
        irdy = !busy && (!m_vld[d] || s_ordy) && !s_fl;
        xfer = m_vld[d] && s_ordy;
        acc  = s_iv && irdy;
        chk({p, ".out_valid"}, 32'(ov), 32'(m_vld[d]));
        chk({p, ".alucontrol"}, 32'(ac), m_ctrl[d]);
        chk({p, ".multi"}, 32'(mu), 32'(m_multi[d]));
        chk({p, ".busy"}, 32'(bs), 32'(busy));
        chk({p, ".in_ready"}, 32'(ir), 32'(irdy));
        chk({p, ".stall"}, 32'(st), 32'(s_iv && !irdy));
        if (s_iv && !irdy) m_stl[d]++;
        if (xfer) m_iss[d]++;
        acc_last[d] = acc;
        if (s_fl) begin
            m_vld[d] = 0; m_multi[d] = 0; m_rem[d] = 0;
        end else begin
            nrem = busy ? m_rem[d] - 1 : 0;
            if (xfer && m_multi[d]) nrem = mc[d];
            m_rem[d] = nrem;
            if (acc) begin
                m_vld[d] = 1;
                m_ctrl[d] = ref_code(s_aop, s_fn);
                m_multi[d] = ref_multi(m_ctrl[d]);
            end else if (xfer) begin
                m_vld[d] = 0;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cycle();
        #2;
`ifdef ALU_SEQ_PERF_EN
        chk("m4.perf_issued", pi4, m_iss[0]);
        chk("m4.perf_stall", ps4, m_stl[0]);
        chk("m0.perf_issued", pi0, m_iss[1]);
        chk("m0.perf_stall", ps0, m_stl[1]);
`endif
        step(0, bus4.out_valid, bus4.alucontrol, bus4.multi, bus4.busy, bus4.in_ready, bus4.stall);
        step(1, bus0.out_valid, bus0.alucontrol, bus0.multi, bus0.busy, bus0.in_ready, bus0.stall);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int aop, input int fn, input bit ordy);
        bit done;
        done = 0;
        set_in(1, aop, fn, 0, ordy);
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = acc_last[0];
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout aluop=%0d funct=%0d observed=no_accept expected=accept", aop, fn);
        end
        set_in(0, aop, fn, 0, ordy);
    endtask

    task automatic drain(input int n);
        set_in(0, 0, 0, 0, 1);
        repeat (n) cycle();
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        chk("rst.out_valid", 32'(bus4.out_valid), 0);
        chk("rst.alucontrol", 32'(bus4.alucontrol), 0);
        chk("rst.multi", 32'(bus4.multi), 0);
        chk("rst.busy", 32'(bus4.busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode sweep over every listed Funct plus an undefined one
        for (int i = 0; i < 19; i++) issue(0, funct_tab[i], 1);
        issue(0, 'h3f, 1);
        issue(12, 'h04, 1);
        for (int a = 1; a < 16; a++) issue(a, 0, 1);
        drain(8);

        // Backpressure hold then retire-and-accept in the same cycle
        issue(3, 0, 0);
        set_in(1, 5, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp.alucontrol", 32'(bus4.alucontrol), 6);
            chk("bp.in_ready", 32'(bus4.in_ready), 0);
            chk("bp.stall", 32'(bus4.stall), 1);
            cycle();
        end
        set_in(1, 2, 0, 0, 1);
        settle();
        chk("bp.release_in_ready", 32'(bus4.in_ready), 1);
        cycle();
        set_in(0, 0, 0, 0, 1);
        settle();
        chk("bp.next_alucontrol", 32'(bus4.alucontrol), 2);
        chk("bp.next_out_valid", 32'(bus4.out_valid), 1);
        cycle();
        drain(8);

        // Multiplier window: transfer at T, busy T+1..T+4, next accept at T+5
        issue(0, 'h18, 1);
        set_in(1, 2, 0, 0, 1);
        cycle();
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk("win.busy4", 32'(bus4.busy), 32'(k <= 4));
            chk("win.in_ready4", 32'(bus4.in_ready), 32'(k == 5));
            chk("win.busy0", 32'(bus0.busy), 0);
            cycle();
        end
        drain(8);

        // Flush while busy with an op waiting
        issue(0, 'h19, 1);
        set_in(1, 4, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 1, 0);
        settle();
        chk("fl.busy_before", 32'(bus4.busy), 1);
        chk("fl.out_valid_before", 32'(bus4.out_valid), 1);
        cycle();
        set_in(1, 1, 0, 0, 1);
        settle();
        chk("fl.busy", 32'(bus4.busy), 0);
        chk("fl.out_valid", 32'(bus4.out_valid), 0);
        chk("fl.in_ready", 32'(bus4.in_ready), 1);
        cycle();
        drain(8);

        // Asynchronous reset between edges in the middle of the window
        issue(0, 'h18, 1);
        set_in(1, 3, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0);
        settle();
        chk("ar.busy_before", 32'(bus4.busy), 1);
        chk("ar.ctrl_before", 32'(bus4.alucontrol), 6);
        rst_n = 1'b0;
        #1;
        chk("ar.out_valid", 32'(bus4.out_valid), 0);
        chk("ar.busy", 32'(bus4.busy), 0);
        chk("ar.alucontrol", 32'(bus4.alucontrol), 0);
        chk("ar.out_valid0", 32'(bus0.out_valid), 0);
        chk("ar.alucontrol0", 32'(bus0.alucontrol), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle();

        // Ten transfers and four stall cycles after reset
        for (int k = 0; k < 10; k++) begin
            set_in(1, 1, 0, 0, 1);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            set_in(1, 1, 0, 0, 0);
            cycle();
        end
        set_in(0, 1, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 1);
        settle();
`ifdef ALU_SEQ_PERF_EN
        chk("perf.issued", pi4, 10);
        chk("perf.stall", ps4, 4);
`endif
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r, aop, fn;
            r = $urandom_range(0, 9);
            aop = (r < 5) ? 0 : (r < 7) ? 12 : $urandom_range(0, 15);
            fn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : funct_tab[$urandom_range(0, 18)];
            set_in($urandom_range(0, 3) != 0, aop, fn, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 3) != 0);
            cycle();
        end
        drain(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
